// File: rtl/finalization.sv
// ACORN-128 finalization: runs STEPS state updates with m = 0, ca = cb = 1 and
// collects the last TAG_BITS keystream bits as the authentication tag.
module finalization #(
    parameter int unsigned STEPS    = 768,
    parameter int unsigned TAG_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [292:0]        state_in,
    output logic                busy,
    output logic                done,
    output logic                tag_valid,
    output logic [TAG_BITS-1:0] tag_out,
    output logic [292:0]        state_out
);

    localparam int unsigned TagStart = STEPS - TAG_BITS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [292:0]        state_q, state_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic                tag_valid_q, tag_valid_d;

    logic [292:0]        s_mix;
    logic [292:0]        s_next;
    logic                ks;
    logic                fb;
    logic [9:0]          tag_off;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Six LFSR feedback XORs are applied in order; later ones see earlier results.
    always_comb begin
        s_mix      = state_q;
        s_mix[289] = s_mix[289] ^ s_mix[235] ^ s_mix[230];
        s_mix[230] = s_mix[230] ^ s_mix[196] ^ s_mix[193];
        s_mix[193] = s_mix[193] ^ s_mix[160] ^ s_mix[154];
        s_mix[154] = s_mix[154] ^ s_mix[111] ^ s_mix[107];
        s_mix[107] = s_mix[107] ^ s_mix[66]  ^ s_mix[61];
        s_mix[61]  = s_mix[61]  ^ s_mix[23]  ^ s_mix[0];
        ks = s_mix[12] ^ s_mix[154] ^ maj(s_mix[235], s_mix[61], s_mix[193])
           ^ ch(s_mix[230], s_mix[111], s_mix[66]);
        fb = s_mix[0] ^ ~s_mix[107] ^ maj(s_mix[244], s_mix[23], s_mix[160])
           ^ s_mix[196] ^ ks;
        s_next = {fb, s_mix[292:1]};
    end

    assign tag_off = cnt_q - 10'(TagStart);

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    state_d     = state_in;
                    cnt_d       = '0;
                    tag_valid_d = 1'b0;
                    fsm_d       = StRun;
                end
            end
            StRun: begin
                state_d = s_next;
                if (cnt_q >= 10'(TagStart)) begin
                    for (int i = 0; i < TAG_BITS; i++) begin
                        if (tag_off == 10'(i)) tag_d[i] = ks;
                    end
                end
                if (cnt_q == 10'(STEPS - 1)) begin
                    cnt_d       = '0;
                    tag_valid_d = 1'b1;
                    fsm_d       = StDone;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StDone: fsm_d = StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= StIdle;
            cnt_q       <= '0;
            state_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    assign busy      = (fsm_q != StIdle);
    assign done      = (fsm_q == StDone);
    assign tag_valid = tag_valid_q;
    assign tag_out   = tag_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_finalization.sv
// Directed bench for finalization: timing, tag/state against a bit-serial
// reference of the ACORN-128 finalization, start-ignore, mid-run reset, back-to-back.
module tb_finalization;

    logic         clk;
    logic         rst;
    logic         start;
    logic [292:0] state_in;
    logic         busy;
    logic         done;
    logic         tag_valid;
    logic [127:0] tag_out;
    logic [292:0] state_out;

    int n_cmp;
    int n_err;

    logic [292:0] st_a, st_b, st_c;
    logic [127:0] tag_a, tag_b;
    logic [292:0] fin_a, fin_b;
    int           done_cnt;

    finalization dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .busy      (busy),
        .done      (done),
        .tag_valid (tag_valid),
        .tag_out   (tag_out),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [292:0] obs, input logic [292:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic bit f_maj(input bit x, input bit y, input bit z);
        return (x && y) || (x && z) || (y && z);
    endfunction

    function automatic bit f_ch(input bit x, input bit y, input bit z);
        return x ? y : z;
    endfunction

    // Reference: 768 steps on an unpacked bit array, keystream of steps 640..767 -> tag.
    task automatic ref_model(input logic [292:0] s0, output logic [127:0] t,
                             output logic [292:0] sf);
        bit s[293];
        bit k, f;
        for (int i = 0; i < 293; i++) s[i] = s0[i];
        t = '0;
        for (int step = 0; step < 768; step++) begin
            s[289] = s[289] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66] ^ s[61];
            s[61]  = s[61] ^ s[23] ^ s[0];
            k = s[12] ^ s[154] ^ f_maj(s[235], s[61], s[193]) ^ f_ch(s[230], s[111], s[66]);
            f = s[0] ^ !s[107] ^ f_maj(s[244], s[23], s[160]) ^ s[196] ^ k;
            for (int j = 0; j < 292; j++) s[j] = s[j + 1];
            s[292] = f;
            if (step >= 640) t[step - 640] = k;
        end
        for (int i = 0; i < 293; i++) sf[i] = s[i];
    endtask

    function automatic logic [292:0] rand293();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r[292:0];
    endfunction

    // One run from a 1-cycle start; optional extra starts at k=100 and in the DONE cycle.
    task automatic run_single(input logic [292:0] s, input logic [127:0] t_exp,
                              input logic [292:0] f_exp, input bit inject);
        int pulses;
        pulses = 0;
        state_in = s;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 770; k++) begin
            if (k == 1 || k == 769 || k == 770) chk("busy", {292'b0, busy}, {292'b0, k <= 769});
            else if (busy !== 1'b1) chk("busy_run", {292'b0, busy}, 293'd1);
            if (done === 1'b1) pulses++;
            if (k == 769) begin
                chk("done_at_769", {292'b0, done}, 293'd1);
                chk("tag_valid_769", {292'b0, tag_valid}, 293'd1);
                chk("tag_out", {165'b0, tag_out}, {165'b0, t_exp});
                chk("state_out", state_out, f_exp);
            end
            if (k == 1) chk("tag_valid_low", {292'b0, tag_valid}, 293'd0);
            if (k == 770) begin
                chk("tag_hold", {165'b0, tag_out}, {165'b0, t_exp});
                chk("tag_valid_hold", {292'b0, tag_valid}, 293'd1);
            end
            if (inject && (k == 100 || k == 769)) begin
                start    = 1'b1;
                state_in = st_c;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulses", 293'(pulses), 293'd1);
        chk("idle_after", {292'b0, busy}, 293'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        start    = 1'b1;
        state_in = rand293();
        st_a     = '0;
        st_b     = {5'h15, {9{32'hA5C3_0F96}}};
        st_c     = rand293();
        ref_model(st_a, tag_a, fin_a);
        ref_model(st_b, tag_b, fin_b);

        // Reset held with start high and random state_in.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_busy", {292'b0, busy}, 293'd0);
            chk("rst_done", {292'b0, done}, 293'd0);
            chk("rst_tag_valid", {292'b0, tag_valid}, 293'd0);
            chk("rst_tag_out", {165'b0, tag_out}, 293'd0);
            chk("rst_state_out", state_out, 293'd0);
            state_in = rand293();
        end
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_start", {292'b0, busy}, 293'd0);
        end

        // Latency and result for zero state, then B with ignored extra starts.
        run_single(st_a, tag_a, fin_a, 1'b0);
        run_single(st_b, tag_b, fin_b, 1'b1);

        // Reset mid-run, then a fresh full run of the same state.
        state_in = st_a;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (699) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {292'b0, busy}, 293'd0);
        chk("midrst_tag_valid", {292'b0, tag_valid}, 293'd0);
        chk("midrst_tag_out", {165'b0, tag_out}, 293'd0);
        @(negedge clk);
        chk("midrst_tag_valid2", {292'b0, tag_valid}, 293'd0);
        @(negedge clk);
        rst = 1'b1;
        run_single(st_a, tag_a, fin_a, 1'b0);

        // Back-to-back: start held high, A then B.
        done_cnt = 0;
        state_in = st_a;
        start    = 1'b1;
        @(negedge clk);
        state_in = st_b;
        for (int k = 1; k <= 1540; k++) begin
            if (done === 1'b1) done_cnt++;
            if (k == 769) begin
                chk("b2b_done1", {292'b0, done}, 293'd1);
                chk("b2b_tag_a", {165'b0, tag_out}, {165'b0, tag_a});
            end
            if (k == 770) begin
                chk("b2b_idle", {292'b0, busy}, 293'd0);
                chk("b2b_tag_a_hold", {165'b0, tag_out}, {165'b0, tag_a});
            end
            if (k == 771) begin
                chk("b2b_busy2", {292'b0, busy}, 293'd1);
                chk("b2b_tv_clear", {292'b0, tag_valid}, 293'd0);
                start = 1'b0;
            end
            if (k == 1539) begin
                chk("b2b_done2", {292'b0, done}, 293'd1);
                chk("b2b_tag_b", {165'b0, tag_out}, {165'b0, tag_b});
                chk("b2b_state_b", state_out, fin_b);
            end
            @(negedge clk);
        end
        chk("b2b_pulses", 293'(done_cnt), 293'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/finalization.md
Name: finalization

Overview:
- Final phase of the ACORN-128 datapath, mirroring the initialization block at the other end of the cipher flow.
- Accepts the 293-bit state left after associated-data and plaintext/ciphertext processing.
- Runs the state update for 768 steps with message bit 0 and ca = cb = 1.
- Collects the last 128 keystream bits as the authentication tag and hands tag plus final state to the top-level controller.

Parameters:
- STEPS, 768, number of finalization state-update steps.
- TAG_BITS, 128, tag length; the tag is taken from keystream steps STEPS-TAG_BITS .. STEPS-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (rst = 0 resets).
- start  input  1  request to begin finalization; sampled only in IDLE.
- state_in  input  293  cipher state at end of encryption/decryption phase; sampled on the accepting edge.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when the tag becomes valid.
- tag_valid  output  1  high from done until next accepted start or reset.
- tag_out  output  128  authentication tag.
- state_out  output  293  registered state after the final step; valid while tag_valid.

Behaviour:
- Reset (rst low, async): FSM = IDLE, step counter = 0, state register = 0, tag register = 0. Outputs busy = 0, done = 0, tag_valid = 0, tag_out = 0, state_out = 0.
- Step function, per step on state S with m = 0, ca = 1, cb = 1, applied sequentially:
  - S289 ^= S235^S230
  - S230 ^= S196^S193
  - S193 ^= S160^S154
  - S154 ^= S111^S107
  - S107 ^= S66^S61
  - S61 ^= S23^S0
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66)
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ S196 ^ ks
  - Shift: S[j] = S[j+1] for j = 0..291; S292 = f.
  - ks uses the S values after the six XOR updates.
  - Logic must equal state_update128 with ca_in = cb_in = 1 and mbit_in = 0. ks is produced by the same combinational cone.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with start = 1, load state_in into the state register, set counter to 0, clear tag_valid, go to RUN. start = 0 keeps IDLE.
  - RUN: each edge performs one step on the state register.
    - If counter >= STEPS-TAG_BITS, write ks into tag bit (counter - (STEPS-TAG_BITS)). tag_out[0] is the first tag keystream bit (step 640); tag_out[127] is the last (step 767).
    - Counter increments by 1.
    - On the edge performing step STEPS-1 (counter = 767): go to DONE and set tag_valid = 1.
  - DONE: done = 1 for exactly this one cycle; next edge returns to IDLE.
- Latency: accepting edge E0; steps occur on edges E1..E768; done is high in the cycle following E768.
- busy rises the cycle after E0 and falls after the DONE cycle (769 cycles high).
- start while busy is ignored; no queueing.
- Back-to-back: start held high through DONE is accepted on the first IDLE edge.
- tag_out and state_out hold their values until the next accepted start. They are not cleared on return to IDLE.
- Counter is 10 bits wide; it never exceeds 767, and there is no wrap-around path.
- Reset mid-RUN: immediate return to reset values; a partial tag is never exposed (tag_valid = 0).
- state_in changes after E0 have no effect on the run in progress.

Test Plan:
- Reset: hold rst = 0 with start = 1 and random state_in -> busy = 0, done = 0, tag_valid = 0, tag_out = 0, state_out = 0 throughout. Release rst: block stays in IDLE until start is sampled high.
- Latency: state_in = 293'b0, 1-cycle start at edge E0 -> busy = 1 for cycles E0+1..E0+769; done pulses exactly once, in the cycle after E768; tag_valid rises at that same cycle.
- Golden vectors: for key = 0, IV = 0 with empty AD/PT, and for key = 000102..0F, IV = 000102..0F with 16-byte PT, drive the state produced by the existing initialization/processing blocks -> tag_out and state_out bit-exact against the C golden model of ACORN-128 (tag bit i = ks step 640+i).
- Start ignored: pulse start again with a different state_in at E0+100 and at the DONE cycle -> tag_out and timing identical to the single-start run; exactly one done pulse.
- Reset mid-run: assert rst at E0+700 for 2 cycles, then start with the same state_in -> tag_valid = 0 during reset; the fresh run yields the golden tag with full 769-cycle latency.
- Back-to-back: hold start = 1 continuously with state A then state B -> two done pulses 770 cycles apart; tag_out = tag(A) until the second acceptance, then tag(B).
